fft_input_loader: RTL

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

---
 rtl/fft_input_loader.sv | 95 +++++++++
 1 files changed

// File: rtl/fft_input_loader.sv
// Serial-to-parallel loader for an 8-point radix-2 FFT: collects eight samples
// and presents them in bit-reversed order to the first butterfly stage.
module fft_input_loader #(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [2**N-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   x0,
    output logic [2**N-1:0]   x1,
    output logic [2**N-1:0]   x2,
    output logic [2**N-1:0]   x3,
    output logic [2**N-1:0]   x4,
    output logic [2**N-1:0]   x5,
    output logic [2**N-1:0]   x6,
    output logic [2**N-1:0]   x7,
    output logic              frame_err
);

    localparam int unsigned W = 2**N;

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e         state;
    logic [2:0]     cnt;
    logic [W-1:0]   slot [8];

    function automatic logic [2:0] bitrev3(input logic [2:0] c);
        return {c[0], c[1], c[2]};
    endfunction

    // In FULL the next sample can only enter while the current frame leaves.
    assign in_ready = (state == StFill) | out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StFill;
            cnt       <= 3'd0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                slot[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                StFill: begin
                    if (in_valid) begin
                        if (in_first && cnt != 3'd0) begin
                            // Resync: restart the frame at this word, stale slots stay hidden.
                            slot[0]   <= in_data;
                            cnt       <= 3'd1;
                            frame_err <= 1'b1;
                        end else begin
                            slot[bitrev3(cnt)] <= in_data;
                            cnt                <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                state     <= StFull;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        state     <= StFill;
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            slot[0] <= in_data;
                            cnt     <= 3'd1;
                        end else begin
                            cnt     <= 3'd0;
                        end
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

    assign x0 = slot[0];
    assign x1 = slot[1];
    assign x2 = slot[2];
    assign x3 = slot[3];
    assign x4 = slot[4];
    assign x5 = slot[5];
    assign x6 = slot[6];
    assign x7 = slot[7];

endmodule
